// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select, enable and ALU op from the current state.
module mips_multicycle_control #(
  parameter int MEM_LATENCY     = 0,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ImmZeroExt,
  output logic [3:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] state_out,
  output logic       instr_retired,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    EXEC_I   = 4'd9,
    JUMP     = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] LAT = MEM_LATENCY[3:0];

  state_t     state;
  state_t     next;
  logic [3:0] cnt;
  logic [5:0] op_q;
  logic [5:0] fn_q;
  logic       ill_q;
  logic       last_wait;

  logic d_r;
  logic d_mem;
  logic d_br;
  logic d_imm;
  logic d_j;
  logic d_legal;

  function automatic logic r_legal(input logic [5:0] f);
    unique case (f)
      FN_SLL, FN_SRL, FN_ADD, FN_SUB,
      FN_AND, FN_OR, FN_SLT: r_legal = 1'b1;
      default:               r_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] f);
    unique case (f)
      FN_SLL:  r_alu = ALU_SLL;
      FN_SRL:  r_alu = ALU_SRL;
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_SLT:  r_alu = ALU_SLT;
      default: r_alu = ALU_ADD;
    endcase
  endfunction

  assign last_wait = (cnt == LAT);

  // Classification of the live IR fields, used only while in DECODE
  always_comb begin
    d_r     = (opcode == OP_R) && r_legal(funct);
    d_mem   = (opcode == OP_LW) || (opcode == OP_SW);
    d_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
    d_imm   = (opcode == OP_ADDI) || (opcode == OP_ANDI)
            || (opcode == OP_ORI);
    d_j     = (opcode == OP_J);
    d_legal = d_r | d_mem | d_br | d_imm | d_j;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= 4'd0;
      op_q  <= 6'd0;
      fn_q  <= 6'd0;
      ill_q <= 1'b0;
    end else begin
      state <= next;
      cnt   <= (next == state) ? cnt + 4'd1 : 4'd0;
      if (state == DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (next == TRAP)
        ill_q <= 1'b1;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      FETCH:    if (last_wait) next = DECODE;
      DECODE: begin
        unique case (1'b1)
          d_mem:   next = MEMADR;
          d_r:     next = EXEC_R;
          d_br:    next = BRANCH;
          d_imm:   next = EXEC_I;
          d_j:     next = JUMP;
          default: next = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        endcase
      end
      MEMADR:   next = (op_q == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (last_wait) next = MEMWB;
      MEMWRITE: if (last_wait) next = FETCH;
      EXEC_R:   next = ALUWB;
      EXEC_I:   next = ALUWB;
      MEMWB:    next = FETCH;
      ALUWB:    next = FETCH;
      BRANCH:   next = FETCH;
      JUMP:     next = FETCH;
      TRAP:     next = TRAP;
      default:  next = FETCH;
    endcase
  end

  always_comb begin
    IorD          = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 2'd0;
    ALUSrcB       = 2'd0;
    ImmZeroExt    = 1'b0;
    ALUControl    = 4'd0;
    PCSrc         = 2'd0;
    PCEn          = 1'b0;
    instr_retired = 1'b0;
    if (!reset) begin
      unique case (state)
        FETCH: begin
          ALUSrcB    = 2'd1;
          ALUControl = ALU_ADD;
          IRWrite    = last_wait;
          PCEn       = last_wait;
        end
        DECODE: begin
          ALUSrcB       = 2'd3;
          ALUControl    = ALU_ADD;
          instr_retired = !d_legal && !TRAP_ON_ILLEGAL;
        end
        MEMADR: begin
          ALUSrcA    = 2'd1;
          ALUSrcB    = 2'd2;
          ALUControl = ALU_ADD;
        end
        MEMREAD: IorD = 1'b1;
        MEMWB: begin
          MemtoReg      = 1'b1;
          RegWrite      = 1'b1;
          instr_retired = 1'b1;
        end
        MEMWRITE: begin
          IorD          = 1'b1;
          MemWrite      = 1'b1;
          instr_retired = last_wait;
        end
        EXEC_R: begin
          ALUSrcA    = (fn_q == FN_SLL || fn_q == FN_SRL) ? 2'd2 : 2'd1;
          ALUControl = r_alu(fn_q);
        end
        ALUWB: begin
          RegWrite      = 1'b1;
          RegDst        = (op_q == OP_R);
          instr_retired = 1'b1;
        end
        BRANCH: begin
          ALUSrcA       = 2'd1;
          ALUControl    = ALU_SUB;
          PCSrc         = 2'd1;
          // Only the branch decision is allowed to follow zero combinationally
          PCEn          = (op_q == OP_BEQ) ? zero : ~zero;
          instr_retired = 1'b1;
        end
        EXEC_I: begin
          ALUSrcA    = 2'd1;
          ALUSrcB    = 2'd2;
          ImmZeroExt = (op_q == OP_ANDI) || (op_q == OP_ORI);
          unique case (1'b1)
            op_q == OP_ANDI: ALUControl = ALU_AND;
            op_q == OP_ORI:  ALUControl = ALU_OR;
            default:         ALUControl = ALU_ADD;
          endcase
        end
        JUMP: begin
          PCSrc         = 2'd2;
          PCEn          = 1'b1;
          instr_retired = 1'b1;
        end
        TRAP: ;
        default: ;
      endcase
    end
  end

  assign state_out     = reset ? 4'd0 : state;
  assign illegal_instr = ill_q & ~reset;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: four parameter sets, random programs,
// per-instruction scoreboard against a spec-level model.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
  } ins_t;

  typedef struct {
    int cyc;
    int rw;
    int rd;
    int m2r;
    int mw;
    int pcen;
    int irw;
    int alu;
    int srca;
    int zx;
  } exp_t;

  localparam int LS[4] = '{0, 2, 3, 1};
  localparam bit TS[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  localparam int NRAND = 24;

  logic clk;
  int   pass_cnt;
  int   total_cnt;
  int   ndone;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int g, int act, int ex);
    total_cnt++;
    if (act == ex) pass_cnt++;
    else $display("FAIL %s cfg%0d: got %0d expected %0d", nm, g, act, ex);
  endfunction

  function automatic bit is_legal(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00)
      return fn inside {6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    return op inside {6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D,
                      6'h23, 6'h2B};
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e = '{cyc: 0, rw: 0, rd: -1, m2r: -1, mw: 0, pcen: 0, irw: 0,
          alu: -1, srca: -1, zx: -1};
    return e;
  endfunction

  // Expected per-instruction totals from the instruction-level rules
  function automatic exp_t model(ins_t i, int L);
    exp_t m;
    m = blank();
    m.irw  = 1;
    m.pcen = 1;
    if (!is_legal(i.op, i.fn)) begin
      m.cyc = 2 + L;
      return m;
    end
    case (i.op)
      6'h00: begin
        m.cyc = 4 + L; m.rw = 1; m.rd = 1; m.m2r = 0; m.zx = 0;
        m.srca = (i.fn == 6'h00 || i.fn == 6'h02) ? 2 : 1;
        case (i.fn)
          6'h00:   m.alu = 8;
          6'h02:   m.alu = 9;
          6'h20:   m.alu = 2;
          6'h22:   m.alu = 3;
          6'h24:   m.alu = 5;
          6'h25:   m.alu = 6;
          default: m.alu = 7;
        endcase
      end
      6'h08, 6'h0C, 6'h0D: begin
        m.cyc = 4 + L; m.rw = 1; m.rd = 0; m.m2r = 0; m.srca = 1;
        m.alu = (i.op == 6'h08) ? 2 : (i.op == 6'h0C) ? 5 : 6;
        m.zx  = (i.op == 6'h08) ? 0 : 1;
      end
      6'h23: begin
        m.cyc = 5 + 2 * L; m.rw = 1; m.rd = 0; m.m2r = 1;
      end
      6'h2B: begin
        m.cyc = 4 + 2 * L; m.mw = L + 1;
      end
      6'h04: begin
        m.cyc = 3 + L; m.pcen += i.z ? 1 : 0;
      end
      6'h05: begin
        m.cyc = 3 + L; m.pcen += i.z ? 0 : 1;
      end
      default: begin
        m.cyc = 3 + L; m.pcen = 2;
      end
    endcase
    return m;
  endfunction

  function automatic ins_t rand_ins(bit ill_ok);
    ins_t e;
    logic [5:0] ops[9] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08,
                           6'h0C, 6'h0D, 6'h23, 6'h2B};
    logic [5:0] fns[7] = '{6'h00, 6'h02, 6'h20, 6'h22,
                           6'h24, 6'h25, 6'h2A};
    e.z  = 1'($urandom);
    e.fn = 6'($urandom);
    if (ill_ok && $urandom_range(0, 5) == 0) begin
      do begin
        e.op = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom);
        e.fn = 6'($urandom);
      end while (is_legal(e.op, e.fn));
    end else begin
      e.op = ops[$urandom_range(0, 8)];
      if (e.op == 6'h00) e.fn = fns[$urandom_range(0, 6)];
    end
    return e;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int L = LS[g];
    localparam bit T = TS[g];

    logic       rst;
    logic [5:0] opc;
    logic [5:0] fnc;
    logic       zero;
    logic       iord, mw, irw, rdst, m2r, rw, zx, pcen, ret, ill;
    logic [1:0] srca, srcb, pcsrc;
    logic [3:0] aluc, st;

    ins_t prog[$];
    exp_t expq[$];
    exp_t acc;
    int   ret_cyc;

    mips_multicycle_control #(
      .MEM_LATENCY(L),
      .TRAP_ON_ILLEGAL(T)
    ) dut (
      .clk(clk),
      .reset(rst),
      .opcode(opc),
      .funct(fnc),
      .zero(zero),
      .IorD(iord),
      .MemWrite(mw),
      .IRWrite(irw),
      .RegDst(rdst),
      .MemtoReg(m2r),
      .RegWrite(rw),
      .ALUSrcA(srca),
      .ALUSrcB(srcb),
      .ImmZeroExt(zx),
      .ALUControl(aluc),
      .PCSrc(pcsrc),
      .PCEn(pcen),
      .state_out(st),
      .instr_retired(ret),
      .illegal_instr(ill)
    );

    function automatic int outs();
      return int'({iord, mw, irw, rdst, m2r, rw, srca, srcb, zx,
                   aluc, pcsrc, pcen, ret});
    endfunction

    // Instruction register: loads the next program word on IRWrite
    always @(posedge clk) begin : irm
      ins_t e;
      if (irw && prog.size() > 0) begin
        e = prog.pop_front();
        opc  <= e.op;
        fnc  <= e.fn;
        zero <= e.z;
      end
    end

    always @(negedge clk) begin : mon
      exp_t e;
      if (rst) begin
        acc = blank();
      end else begin
        acc.cyc++;
        if (rw) begin
          acc.rw++;
          acc.rd  = int'(rdst);
          acc.m2r = int'(m2r);
        end
        if (mw) acc.mw++;
        if (pcen) acc.pcen++;
        if (irw) acc.irw++;
        if (st == 4'd6 || st == 4'd9) begin
          acc.alu  = int'(aluc);
          acc.srca = int'(srca);
          acc.zx   = int'(zx);
        end
        if (ret) begin
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("cycles", g, acc.cyc, e.cyc);
            chk("regwrite", g, acc.rw, e.rw);
            chk("regdst", g, acc.rd, e.rd);
            chk("memtoreg", g, acc.m2r, e.m2r);
            chk("memwrite", g, acc.mw, e.mw);
            chk("pcen", g, acc.pcen, e.pcen);
            chk("irwrite", g, acc.irw, e.irw);
            chk("aluctl", g, acc.alu, e.alu);
            chk("alusrca", g, acc.srca, e.srca);
            chk("immzx", g, acc.zx, e.zx);
          end
          ret_cyc = cyc;
          acc = blank();
        end
      end
    end

    function automatic void push(ins_t e);
      prog.push_back(e);
      expq.push_back(model(e, L));
    endfunction

    initial begin : stim
      int n;
      int k;
      rst  = 1'b1;
      opc  = 6'd0;
      fnc  = 6'd0;
      zero = 1'b0;
      acc  = blank();
      ret_cyc = 0;
      push('{6'h00, 6'h20, 1'b0});
      push('{6'h23, 6'h00, 1'b0});
      push('{6'h2B, 6'h00, 1'b1});
      push('{6'h04, 6'h00, 1'b1});
      push('{6'h04, 6'h00, 1'b0});
      push('{6'h05, 6'h00, 1'b0});
      push('{6'h05, 6'h00, 1'b1});
      push('{6'h02, 6'h00, 1'b0});
      push('{6'h00, 6'h00, 1'b0});
      push('{6'h0D, 6'h00, 1'b0});
      if (!T) push('{6'h3F, 6'h00, 1'b0});
      for (int i = 0; i < NRAND; i++) push(rand_ins(!T));
      if (T) prog.push_back('{6'h3F, 6'($urandom), 1'b0});
      else prog.push_back('{6'h2B, 6'h00, 1'b0});

      repeat (2) @(negedge clk);
      chk("rst_state", g, int'(st), 0);
      chk("rst_outs", g, outs(), 0);
      chk("rst_illegal", g, int'(ill), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("first_fetch", g, int'(st), 0);

      for (int i = 0; i < 4000 && expq.size() > 0; i++) @(posedge clk);
      chk("queue_drained", g, expq.size(), 0);

      if (T) begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (st == 4'd11) break;
        end
        n = cyc - ret_cyc;
        chk("trap_reached", g, int'(st), 11);
        chk("trap_latency", g, n, L + 3);
        chk("trap_illegal", g, int'(ill), 1);
        repeat (3) @(negedge clk);
        chk("trap_hold", g, int'(st), 11);
        chk("trap_sticky", g, int'(ill), 1);
        chk("trap_enables", g, int'({mw, irw, rw, pcen}), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("trap_rst_state", g, int'(st), 0);
        chk("trap_rst_illegal", g, int'(ill), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("trap_rst_fetch", g, int'(st), 0);
        chk("trap_rst_clear", g, int'(ill), 0);
      end else begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (st == 4'd5) break;
        end
        chk("sw_reached", g, int'(st), 5);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_memwrite", g, int'(mw), 0);
        chk("abort_outs", g, outs(), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
          @(negedge clk);
          if (i == 1) chk("abort_fetch", g, int'(st), 0);
          if (irw) begin
            k = i;
            break;
          end
        end
        chk("abort_irwrite_delay", g, k, L + 1);
      end
      ndone++;
    end
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    ndone     = 0;
    for (int i = 0; i < 20000 && ndone < 4; i++) @(posedge clk);
    chk("all_done", -1, ndone, 4);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
